// File: rtl/run_pkg.sv
// Shared types and helpers for the run sequencer: FSM states, result codes and run length.
package run_pkg;

    localparam int unsigned RESULT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [RESULT_W-1:0] {
        UNKNOWN = 2'b00,
        POS     = 2'b01,
        NEG     = 2'b10
    } result_t;

    // Cycles the downstream network needs to evaluate one pixel word.
    function automatic int unsigned run_cycles(input int unsigned width, input int unsigned height);
        return height * (32'd1 << (width + 32'd2));
    endfunction

endpackage

// File: rtl/pixel_shifter.sv
// Serial-in pixel shift register with a saturating bit counter that flags a full load.
module pixel_shifter #(
    parameter  int unsigned HEIGHT = 7,
    localparam int unsigned CNT_W  = $clog2(HEIGHT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift,
    input  logic              restart,
    input  logic              clear,
    input  logic              shift_bit,
    output logic [HEIGHT-1:0] pixels,
    output logic [CNT_W-1:0]  bit_cnt,
    output logic              loaded_c
);

    assign loaded_c = (bit_cnt == CNT_W'(HEIGHT));

    // First bit received ends up in the MSB once HEIGHT bits have been shifted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixels  <= '0;
            bit_cnt <= '0;
        end else begin
            if (shift) begin
                pixels <= {pixels[HEIGHT-2:0], shift_bit};
            end
            if (clear) begin
                bit_cnt <= '0;
            end else if (shift && restart) begin
                bit_cnt <= CNT_W'(1);
            end else if (shift && !loaded_c) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Loads a serial pixel word, kicks the downstream network, waits out its run and captures the result.
module run_sequencer
    import run_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 7,
    parameter int unsigned SETTLE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_en,
    input  logic                shift_bit,
    input  logic                go,
    input  logic                ack,
    input  logic [RESULT_W-1:0] neuron_out,
    output logic [HEIGHT-1:0]   pixels,
    output logic                start,
    output logic                busy,
    output logic [RESULT_W-1:0] result,
    output logic                result_valid
);

    localparam int unsigned RUN_LEN   = run_cycles(WIDTH, HEIGHT) + SETTLE;
    localparam int unsigned RUN_CNT_W = $clog2(RUN_LEN + 1);
    localparam int unsigned BIT_CNT_W = $clog2(HEIGHT + 1);

    state_t                state, state_nx;
    logic [RUN_CNT_W-1:0]  run_cnt, run_cnt_nx;
    logic [RESULT_W-1:0]   result_nx;
    logic                  valid_nx;
    logic                  start_nx;
    logic                  busy_nx;
    logic                  shift_c;
    logic                  restart_c;
    logic                  clear_c;
    logic                  loaded_c;
    logic                  run_last_c;
    logic [BIT_CNT_W-1:0]  bit_cnt;

    pixel_shifter #(
        .HEIGHT (HEIGHT)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .shift     (shift_c),
        .restart   (restart_c),
        .clear     (clear_c),
        .shift_bit (shift_bit),
        .pixels    (pixels),
        .bit_cnt   (bit_cnt),
        .loaded_c  (loaded_c)
    );

    assign run_last_c = (run_cnt == RUN_CNT_W'(RUN_LEN - 1));

    // State, run counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            run_cnt      <= '0;
            start        <= 1'b0;
            busy         <= 1'b0;
            result       <= UNKNOWN;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nx;
            run_cnt      <= run_cnt_nx;
            start        <= start_nx;
            busy         <= busy_nx;
            result       <= result_nx;
            result_valid <= valid_nx;
        end
    end

    // Next-state logic; shift/go/ack only matter outside START and RUN.
    always_comb begin
        state_nx   = state;
        run_cnt_nx = run_cnt;
        result_nx  = result;
        valid_nx   = result_valid;
        shift_c    = 1'b0;
        restart_c  = 1'b0;
        clear_c    = 1'b0;
        start_nx   = 1'b0;
        busy_nx    = 1'b0;
        case (state)
            IDLE: begin
                shift_c = shift_en;
                if (go && loaded_c) begin
                    state_nx = START;
                end
            end
            START: begin
                run_cnt_nx = '0;
                state_nx   = RUN;
            end
            RUN: begin
                if (run_last_c) begin
                    result_nx = neuron_out;
                    valid_nx  = 1'b1;
                    clear_c   = 1'b1;
                    state_nx  = DONE;
                end else begin
                    run_cnt_nx = run_cnt + RUN_CNT_W'(1);
                end
            end
            DONE: begin
                // A new load wins over ack and starts the bit count afresh.
                if (shift_en) begin
                    shift_c   = 1'b1;
                    restart_c = 1'b1;
                    valid_nx  = 1'b0;
                    state_nx  = IDLE;
                end else if (ack) begin
                    valid_nx = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        start_nx = (state_nx == START);
        busy_nx  = (state_nx == START) || (state_nx == RUN);
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized and directed checks of run_sequencer against a cycle-timeline reference model.
module tb_run_sequencer;
    import run_pkg::*;

    localparam int H        = 7;
    localparam int BUSY_LEN = 7 * 1024 + 4 + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         shift_en, shift_bit, go, ack;
    logic [1:0]   neuron_out;
    logic [H-1:0] pixels;
    logic         start, busy, result_valid;
    logic [1:0]   result;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a run is a time window rather than a state machine.
    logic [H-1:0] m_pix;
    int           m_cnt;
    int           m_res;
    bit           m_valid;
    bit           m_running;
    bit           m_start;
    longint       edge_n;
    longint       cap_edge;

    run_sequencer #(.WIDTH(8), .HEIGHT(H), .SETTLE(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .shift_en     (shift_en),
        .shift_bit    (shift_bit),
        .go           (go),
        .ack          (ack),
        .neuron_out   (neuron_out),
        .pixels       (pixels),
        .start        (start),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pix     = '0;
        m_cnt     = 0;
        m_res     = 0;
        m_valid   = 0;
        m_running = 0;
        m_start   = 0;
    endtask

    task automatic model_edge(input bit se, input bit sb, input bit g, input bit a, input int no);
        bit was_loaded;
        edge_n++;
        m_start = 0;
        if (!rst) begin
            model_reset();
        end else if (m_running) begin
            if (edge_n == cap_edge) begin
                m_res     = no;
                m_valid   = 1;
                m_cnt     = 0;
                m_running = 0;
            end
        end else if (m_valid) begin
            if (se) begin
                m_pix   = {m_pix[H-2:0], sb};
                m_cnt   = 1;
                m_valid = 0;
            end else if (a) begin
                m_valid = 0;
            end
        end else begin
            was_loaded = (m_cnt == H);
            if (se) begin
                m_pix = {m_pix[H-2:0], sb};
                if (m_cnt < H) m_cnt++;
            end
            if (g && was_loaded) begin
                m_running = 1;
                m_start   = 1;
                cap_edge  = edge_n + BUSY_LEN;
            end
        end
    endtask

    task automatic check_all();
        check_eq("pixels", int'(pixels), int'(m_pix));
        check_eq("start", int'(start), int'(m_start));
        check_eq("busy", int'(busy), int'(m_running));
        check_eq("result", int'(result), m_res);
        check_eq("result_valid", int'(result_valid), int'(m_valid));
        check_eq("bit_cnt", int'(dut.u_shifter.bit_cnt), m_cnt);
    endtask

    task automatic tick(input bit se, input bit sb, input bit g, input bit a, input int no);
        shift_en   = se;
        shift_bit  = sb;
        go         = g;
        ack        = a;
        neuron_out = 2'(no);
        @(posedge clk);
        model_edge(se, sb, g, a, no);
        #1;
        check_all();
    endtask

    task automatic load_word(input logic [H-1:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) tick(1'b1, w[H-1-i], 1'b0, 1'b0, 0);
    endtask

    task automatic wait_done(input int no, input bit noisy);
        int guard = 0;
        while (m_running && guard < BUSY_LEN + 10) begin
            tick(noisy ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)),
                 noisy ? 1'($urandom_range(0, 1)) : 1'b0,
                 noisy ? 1'($urandom_range(0, 1)) : 1'b0, no);
            guard++;
        end
        check_eq("run_timeout", int'(m_running), 0);
    endtask

    initial begin
        int busy_seen;
        int start_seen;
        logic [H-1:0] w;

        rst = 1'b0; shift_en = 0; shift_bit = 0; go = 0; ack = 0; neuron_out = 0;
        edge_n = 0; cap_edge = 0;
        model_reset();
        #1;
        check_all();
        #10 rst = 1'b1;

        // Directed load 1011001, noisy inputs during the run, neuron_out = POS.
        w = 7'b1011001;
        load_word(w, H);
        check_eq("loaded_word", int'(pixels), int'(w));
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1);
        busy_seen  = int'(busy);
        start_seen = int'(start);
        for (int i = 0; i < BUSY_LEN + 3; i++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1);
            busy_seen  += int'(busy);
            start_seen += int'(start);
            if (!busy) break;
        end
        check_eq("busy_len", busy_seen, BUSY_LEN);
        check_eq("start_pulses", start_seen, 1);
        check_eq("pix_held", int'(pixels), int'(w));
        check_eq("pos_result", int'(result), int'(POS));
        check_eq("pos_valid", int'(result_valid), 1);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 2);
        check_eq("ack_valid", int'(result_valid), 0);
        check_eq("ack_result", int'(result), int'(POS));

        // Partial load must not start; completing it must.
        load_word(7'b0110100, 5);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 0);
        check_eq("partial_busy", int'(busy), 0);
        load_word(7'b1100000, 2);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 2);
        check_eq("full_start", int'(start), 1);

        // Reset at RUN cycle 3000 aborts without capture.
        for (int i = 0; i < 3001; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 2);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_eq("rst_pixels", int'(pixels), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_start", int'(start), 0);
        check_eq("rst_result", int'(result), 0);
        check_eq("rst_valid", int'(result_valid), 0);
        check_eq("rst_state", int'(dut.state), int'(IDLE));
        tick(1'b0, 1'b0, 1'b1, 1'b0, 0);
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 1'b0, 0);
        check_eq("no_reload_start", int'(start), 0);

        // DONE with shift_en and ack together: shift wins.
        load_word(7'(($urandom)), H);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 2);
        wait_done(2, 1'b0);
        check_eq("neg_result", int'(result), int'(NEG));
        tick(1'b0, 1'b0, 1'b1, 1'b0, 0);
        check_eq("done_go_ignored", int'(start), 0);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 0);
        check_eq("shift_ack_state", int'(dut.state), int'(IDLE));
        check_eq("shift_ack_cnt", int'(dut.u_shifter.bit_cnt), 1);
        check_eq("shift_ack_valid", int'(result_valid), 0);

        // Random traffic.
        for (int i = 0; i < 30000; i++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
